// File: rtl/p20_obstacle_pkg.sv
// Shared constants, types and the LFSR step for the obstacle field.
// Cactus dimensions are indexed by the 2-bit obstacle type.
package p20_obstacle_pkg;

  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

  // Packed so that element 0 is the rightmost entry: {type3, type2, type1, type0}
  localparam logic [3:0][5:0] TYPE_W = {6'd12, 6'd24, 6'd16, 6'd12};
  localparam logic [3:0][5:0] TYPE_H = {6'd40, 6'd24, 6'd32, 6'd24};

  typedef struct packed {
    logic        valid;
    logic [10:0] x;
    logic [1:0]  obs_type;
  } slot_t;

  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/p20_obstacle_slot.sv
// One obstacle slot: holds world-x and type, retires itself once it has
// scrolled off the left edge, and tests the query pixel against its box.
module p20_obstacle_slot
  import p20_obstacle_pkg::*;
#(
  parameter int GROUND_Y = 400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [10:0] load_x,
  input  logic [1:0]  load_type,
  input  logic [10:0] pos,
  input  logic [9:0]  px_x,
  input  logic [9:0]  px_y,
  output logic        valid,
  output logic        hit
);

  localparam logic [9:0] GROUND = 10'(GROUND_Y);

  slot_t       slot;
  logic [10:0] rel;
  logic [11:0] dx;
  logic [5:0]  w;
  logic [5:0]  h;
  logic [9:0]  y_top;
  logic        retire;

  assign rel    = slot.x - pos;
  // Signed rel in [-1024, -33] means the whole box is left of the screen
  assign retire = rel[10] && (rel < 11'd2016);

  assign w     = TYPE_W[slot.obs_type];
  assign h     = TYPE_H[slot.obs_type];
  assign y_top = GROUND - {4'b0000, h};
  assign dx    = {2'b00, px_x} - {rel[10], rel};

  assign valid = slot.valid;
  assign hit   = slot.valid && !dx[11] && (dx < {6'b000000, w}) &&
                 (px_y >= y_top) && (px_y < GROUND);

  // A load only targets a slot that was free, so it never races a retire
  always_ff @(posedge clk) begin
    if (rst) begin
      slot <= '0;
    end else if (en) begin
      if (load) begin
        slot.valid    <= 1'b1;
        slot.x        <= load_x;
        slot.obs_type <= load_type;
      end else if (slot.valid && retire) begin
        slot.valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/p20_obstacle_field.sv
// Obstacle spawner and per-pixel obstacle query driven by the scroll position.
// Owns the gap counter, the LFSR, the slot allocator and NSLOT slot instances.
module p20_obstacle_field
  import p20_obstacle_pkg::*;
#(
  parameter int          NSLOT       = 4,
  parameter int          SCREEN_W    = 640,
  parameter int          GROUND_Y    = 400,
  parameter int          MIN_GAP     = 160,
  parameter int          INITIAL_GAP = 320,
  parameter logic [15:0] LFSR_SEED   = LFSR_SEED_DEFAULT
) (
  input  logic             clk,
  input  logic             sys_rst,
  input  logic             game_rst,
  input  logic             halt,
  input  logic [10:0]      pos,
  input  logic [9:0]       px_x,
  input  logic [9:0]       px_y,
  output logic             hit,
  output logic [NSLOT-1:0] live_mask,
  output logic [7:0]       spawn_cnt
);

  logic             rst_any;
  logic             run;
  logic [15:0]      lfsr;
  logic [10:0]      pos_q;
  logic [10:0]      gap_left;
  logic [10:0]      delta;
  logic [10:0]      spawn_x;
  logic             spawn_req;
  logic             found;
  logic [NSLOT-1:0] load_vec;
  logic [NSLOT-1:0] slot_valid;
  logic [NSLOT-1:0] slot_hit;

  assign rst_any   = sys_rst | game_rst;
  assign run       = ~halt;
  assign delta     = pos - pos_q;
  assign spawn_x   = pos + 11'(SCREEN_W);
  assign spawn_req = run && (delta >= gap_left);
  assign live_mask = slot_valid;

  // Lowest free slot at the start of the cycle wins; retiring slots stay busy
  always_comb begin
    load_vec = '0;
    found    = 1'b0;
    for (int i = 0; i < NSLOT; i++) begin
      if (spawn_req && !found && !slot_valid[i]) begin
        load_vec[i] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  // Only a full system reset reseeds, so successive rounds see new sequences
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      lfsr <= LFSR_SEED;
    end else if (!game_rst && run) begin
      lfsr <= lfsr_step(lfsr);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_any) begin
      pos_q     <= '0;
      gap_left  <= 11'(INITIAL_GAP);
      spawn_cnt <= '0;
      hit       <= 1'b0;
    end else begin
      pos_q <= pos;
      hit   <= |slot_hit;
      if (run) begin
        if (spawn_req) begin
          gap_left <= 11'(MIN_GAP) + {4'b0000, lfsr[6:0]};
          if (found && (spawn_cnt != 8'hFF)) begin
            spawn_cnt <= spawn_cnt + 8'd1;
          end
        end else begin
          gap_left <= gap_left - delta;
        end
      end
    end
  end

  for (genvar g = 0; g < NSLOT; g++) begin : g_slot
    p20_obstacle_slot #(
      .GROUND_Y(GROUND_Y)
    ) u_slot (
      .clk      (clk),
      .rst      (rst_any),
      .en       (run),
      .load     (load_vec[g]),
      .load_x   (spawn_x),
      .load_type(lfsr[9:8]),
      .pos      (pos),
      .px_x     (px_x),
      .px_y     (px_y),
      .valid    (slot_valid[g]),
      .hit      (slot_hit[g])
    );
  end

endmodule

// File: tb/tb_p20_obstacle_field.sv
// Directed-plus-random bench for p20_obstacle_field against a behavioural
// model of the obstacle field written in plain integer arithmetic.
module tb_p20_obstacle_field;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic        game_rst;
  logic        halt;
  logic [10:0] pos;
  logic [9:0]  px_x;
  logic [9:0]  px_y;
  logic        hit;
  logic [3:0]  live_mask;
  logic [7:0]  spawn_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit m_valid [4];
  int m_x     [4];
  int m_type  [4];
  int m_pos_q;
  int m_gap;
  int m_cnt;
  int m_lfsr;
  bit m_hit;

  int obs_w [4] = '{12, 16, 24, 12};
  int obs_h [4] = '{24, 32, 24, 40};
  int taps  [4] = '{16, 14, 13, 11};

  p20_obstacle_field dut (
    .clk      (clk),
    .sys_rst  (sys_rst),
    .game_rst (game_rst),
    .halt     (halt),
    .pos      (pos),
    .px_x     (px_x),
    .px_y     (px_y),
    .hit      (hit),
    .live_mask(live_mask),
    .spawn_cnt(spawn_cnt)
  );

  always #20 clk = ~clk;

  function automatic int lfsr_advance(input int s);
    int mask = 0;
    foreach (taps[i]) mask |= (1 << (taps[i] - 1));
    return (s & 1) ? ((s >> 1) ^ mask) : (s >> 1);
  endfunction

  function automatic int signed_rel(input int x, input int p);
    int r = (x - p) & 2047;
    return (r >= 1024) ? r - 2048 : r;
  endfunction

  function automatic int model_mask();
    int m = 0;
    for (int i = 0; i < 4; i++) if (m_valid[i]) m |= (1 << i);
    return m;
  endfunction

  task automatic model_step();
    int  delta;
    int  rel;
    int  dx;
    bit  retire [4];
    bit  placed;
    if (sys_rst || game_rst) begin
      for (int i = 0; i < 4; i++) m_valid[i] = 0;
      m_pos_q = 0;
      m_gap   = 320;
      m_cnt   = 0;
      m_hit   = 0;
      if (sys_rst) m_lfsr = 16'hACE1;
      return;
    end
    m_hit = 0;
    for (int i = 0; i < 4; i++) begin
      rel = signed_rel(m_x[i], int'(pos));
      dx  = int'(px_x) - rel;
      if (m_valid[i] && dx >= 0 && dx < obs_w[m_type[i]] &&
          int'(px_y) >= 400 - obs_h[m_type[i]] && int'(px_y) < 400)
        m_hit = 1;
      retire[i] = m_valid[i] && (rel < -32);
    end
    delta   = (int'(pos) - m_pos_q) & 2047;
    m_pos_q = int'(pos);
    if (!halt) begin
      if (delta >= m_gap) begin
        m_gap  = 160 + (m_lfsr & 127);
        placed = 0;
        for (int i = 0; i < 4; i++) begin
          if (!placed && !m_valid[i]) begin
            m_valid[i] = 1;
            m_x[i]     = (int'(pos) + 640) & 2047;
            m_type[i]  = (m_lfsr >> 8) & 3;
            placed     = 1;
            if (m_cnt < 255) m_cnt++;
          end
        end
      end else begin
        m_gap = m_gap - delta;
      end
      for (int i = 0; i < 4; i++) if (retire[i]) m_valid[i] = 0;
      m_lfsr = lfsr_advance(m_lfsr);
    end
  endtask

  task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit sr, input bit gr, input bit hl, input int p,
                               input int qx, input int qy);
    sys_rst  = sr;
    game_rst = gr;
    halt     = hl;
    pos      = 11'(p);
    px_x     = 10'(qx);
    px_y     = 10'(qy);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    check_value({tag, ".live_mask"}, 32'(live_mask), 32'(model_mask()));
    check_value({tag, ".spawn_cnt"}, 32'(spawn_cnt), 32'(m_cnt));
    check_value({tag, ".hit"},       32'(hit),       32'(m_hit));
  endtask

  task automatic random_tick(input string tag, input bit hl, input int p);
    applyStimulus(0, 0, hl, p, $urandom_range(0, 700), $urandom_range(350, 410));
    checkOutput(tag);
  endtask

  initial begin
    int p;
    int saved_mask;
    int saved_cnt;
    m_lfsr = 0;
    m_gap  = 0;
    m_cnt  = 0;
    m_pos_q = 0;
    m_hit  = 0;
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 0;
      m_x[i]     = 0;
      m_type[i]  = 0;
    end

    // Reset state
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("reset");
    check_value("reset.live_const", 32'(live_mask), 32'd0);
    check_value("reset.cnt_const",  32'(spawn_cnt), 32'd0);

    // First spawn lands when accumulated scroll reaches the initial gap
    for (p = 8; p < 320; p += 8) random_tick("step8", 0, p);
    check_value("pre_spawn.live", 32'(live_mask), 32'd0);
    random_tick("step8", 0, 320);
    check_value("first_spawn.live", 32'(live_mask), 32'b0001);
    check_value("first_spawn.cnt",  32'(spawn_cnt), 32'd1);

    // Pixel queries against the slot at x=960 seen from pos=700
    applyStimulus(0, 0, 0, 700, 260, 368);
    checkOutput("query_in");
    applyStimulus(0, 0, 0, 700, 276, 368);
    checkOutput("query_right");
    applyStimulus(0, 0, 0, 700, 260, 367);
    checkOutput("query_above");
    applyStimulus(0, 0, 0, 700, 259, 399);
    checkOutput("query_left");

    // Fast scroll: slot exhaustion, dropped spawns, retirement, wrap
    p = 700;
    for (int i = 0; i < 40; i++) begin
      p = (p + 255) & 2047;
      random_tick("step255", 0, p);
    end

    // Wrap 2040 -> 8 with 20 left in the gap: no spawn, then spawn on delta 4
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("wrap_reset");
    random_tick("wrap_pre", 0, 300);
    random_tick("wrap_halt", 1, 2040);
    random_tick("wrap_cross", 0, 8);
    check_value("wrap_cross.live", 32'(live_mask), 32'd0);
    check_value("wrap_cross.cnt",  32'(spawn_cnt), 32'd0);
    random_tick("wrap_spawn", 0, 12);
    check_value("wrap_spawn.live", 32'(live_mask), 32'b0001);
    check_value("wrap_spawn.cnt",  32'(spawn_cnt), 32'd1);

    // Halt freezes everything but the query path
    p = 12;
    for (int i = 0; i < 20; i++) begin
      p = (p + 50) & 2047;
      random_tick("pre_halt", 0, p);
    end
    saved_mask = model_mask();
    saved_cnt  = m_cnt;
    for (int i = 0; i < 100; i++) begin
      p = (p + $urandom_range(0, 37)) & 2047;
      random_tick("halt", 1, p);
    end
    check_value("halt.live_frozen", 32'(live_mask), 32'(saved_mask));
    check_value("halt.cnt_frozen",  32'(spawn_cnt), 32'(saved_cnt));
    for (int i = 0; i < 10; i++) begin
      p = (p + 2) & 2047;
      random_tick("release", 0, p);
    end
    check_value("release.no_burst", 32'(spawn_cnt <= 8'(saved_cnt + 1)), 32'd1);

    // Round reset with three live slots, coinciding with a spawn request
    applyStimulus(0, 1, 0, p, 0, 0);
    checkOutput("round_clear");
    for (int i = 0; i < 3; i++) begin
      p = (p + 330) & 2047;
      random_tick("fill3", 0, p);
    end
    check_value("fill3.live", 32'(live_mask), 32'b0111);
    p = (p + 330) & 2047;
    applyStimulus(0, 1, 0, p, 0, 0);
    checkOutput("game_rst");
    check_value("game_rst.live", 32'(live_mask), 32'd0);
    check_value("game_rst.cnt",  32'(spawn_cnt), 32'd0);
    for (int i = 0; i < 30; i++) begin
      p = (p + $urandom_range(60, 255)) & 2047;
      random_tick("post_round", 0, p);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
